// File: rtl/servo_sched.sv
// -----------------------------------------------------------------------------
// servo_sched: multi-channel servo motion scheduler.
//
// A host writes per-channel target positions (0..255) over a valid/ready
// port. Once per frame, each channel's position is slewed toward its target
// by at most STEP. All channels then produce phase-aligned PWM pulses from
// one shared frame counter. The slew and the position-to-width multiply-add
// are shared across channels. They are time-multiplexed in an UPDATE window
// that occupies the last NUM_CH cycles of the frame.
//
// Ports:
//   clk          system clock
//   resetn       asynchronous active-low reset
//   wr_valid     host write request
//   wr_ready     scheduler can accept a write (low during UPDATE)
//   wr_ch        target channel index
//   wr_pos       target position
//   wr_err       one-cycle pulse: a write to a channel >= NUM_CH was accepted
//   ch_en        per-channel PWM enable, sampled every cycle
//   pwm          servo pulse outputs (registered)
//   at_target    channel position equals its target (registered)
//   frame_start  high in the cycle where the frame counter is 0
// -----------------------------------------------------------------------------
module servo_sched #(
    parameter int CLK_FREQUENCY = 12000000,
    parameter int NUM_CH        = 4,
    parameter int FRAME_HZ      = 50,
    parameter int MIN_US        = 1000,
    parameter int MAX_US        = 2000,
    parameter int STEP          = 4,
    parameter int CENTER        = 128
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [3:0]        wr_ch,
    input  logic [7:0]        wr_pos,
    output logic              wr_err,
    input  logic [NUM_CH-1:0] ch_en,
    output logic [NUM_CH-1:0] pwm,
    output logic [NUM_CH-1:0] at_target,
    output logic              frame_start
);

    localparam int FRAME_TICKS = CLK_FREQUENCY / FRAME_HZ;
    localparam int MIN_TICKS   = int'((longint'(MIN_US) * longint'(CLK_FREQUENCY))
                                      / longint'(1000000));
    localparam int LSB_TICKS   = int'((longint'(MAX_US - MIN_US) * longint'(CLK_FREQUENCY))
                                      / longint'(256000000));
    localparam int UPD_START   = FRAME_TICKS - NUM_CH - 1;
    localparam int CNT_W       = ($clog2(FRAME_TICKS) > 18) ? $clog2(FRAME_TICKS) : 18;

    localparam logic [CNT_W-1:0] FRAME_LAST  = CNT_W'(FRAME_TICKS - 1);
    localparam logic [CNT_W-1:0] UPD_START_C = CNT_W'(UPD_START);
    // UPDATE ends one cycle early so that wr_ready is back during the
    // cycle in which the last channel is processed.
    localparam logic [CNT_W-1:0] UPD_LAST_C  = CNT_W'(FRAME_TICKS - 2);
    localparam bit               HAS_STALL   = (NUM_CH > 1);
    localparam logic [7:0]       CENTER_POS  = 8'(CENTER);
    localparam logic [CNT_W-1:0] WIDTH_RST   = CNT_W'(MIN_TICKS + CENTER * LSB_TICKS);
    localparam logic signed [8:0] STEP_S     = 9'(STEP);

    if (STEP < 1 || STEP > 255 || NUM_CH < 1 || NUM_CH > 16) begin : g_bad_cfg
        $error("servo_sched: STEP must be 1..255 and NUM_CH 1..16");
    end
    if (MIN_TICKS + 255 * LSB_TICKS >= UPD_START) begin : g_bad_timing
        $error("servo_sched: longest pulse overlaps the UPDATE window");
    end

    typedef enum logic {S_RUN, S_UPDATE} state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [CNT_W-1:0]  r_frame_cnt;
    logic              r_frame_start;
    logic              r_wr_ready;
    logic              r_wr_err;
    logic [7:0]        r_cur   [NUM_CH];
    logic [7:0]        r_tgt   [NUM_CH];
    logic [CNT_W-1:0]  r_width [NUM_CH];
    logic [NUM_CH-1:0] r_pwm;
    logic [NUM_CH-1:0] r_at_target;

    logic              w_wr_fire;
    logic              w_wr_ch_ok;
    logic              w_upd_active;
    logic [CNT_W-1:0]  w_upd_idx;
    logic [7:0]        w_sel_cur;
    logic [7:0]        w_sel_tgt;
    logic signed [8:0] w_diff;
    logic [7:0]        w_cur_new;
    logic [CNT_W-1:0]  w_width_new;

    assign w_wr_fire    = wr_valid && r_wr_ready;
    assign w_wr_ch_ok   = ({28'd0, wr_ch} < NUM_CH);
    assign w_upd_active = (r_frame_cnt > UPD_START_C);
    assign w_upd_idx    = r_frame_cnt - UPD_START_C - CNT_W'(1);

    // Next-state logic: leave RUN after the write slot at UPD_START; return
    // to RUN for the final frame cycle.
    always_comb begin
        // NOTE: assign a default before any branch so no path leaves the
        // variable unassigned, which would otherwise infer a latch.
        w_state_next = r_state;
        case (r_state)
            S_RUN:    if (HAS_STALL && r_frame_cnt == UPD_START_C) w_state_next = S_UPDATE;
            S_UPDATE: if (r_frame_cnt == UPD_LAST_C) w_state_next = S_RUN;
            default:  w_state_next = S_RUN;
        endcase
    end

    // Shared slew and multiply-add. The frame counter selects the channel
    // being processed in the UPDATE window.
    always_comb begin
        w_sel_cur = '0;
        w_sel_tgt = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_upd_idx == CNT_W'(i)) begin
                w_sel_cur = r_cur[i];
                w_sel_tgt = r_tgt[i];
            end
        end
        w_diff = $signed({1'b0, w_sel_tgt}) - $signed({1'b0, w_sel_cur});
        // Stepping by STEP only happens when the target is more than STEP
        // away, so the result cannot leave 0..255.
        if (w_diff > STEP_S)       w_cur_new = w_sel_cur + 8'(STEP);
        else if (w_diff < -STEP_S) w_cur_new = w_sel_cur - 8'(STEP);
        else                       w_cur_new = w_sel_tgt;
        w_width_new = CNT_W'(MIN_TICKS) + CNT_W'(w_cur_new) * CNT_W'(LSB_TICKS);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state       <= S_RUN;
            r_frame_cnt   <= '0;
            r_frame_start <= 1'b0;
            r_wr_ready    <= 1'b0;
            r_wr_err      <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            r_state       <= w_state_next;
            r_frame_cnt   <= (r_frame_cnt == FRAME_LAST) ? '0 : r_frame_cnt + CNT_W'(1);
            r_frame_start <= (r_frame_cnt == FRAME_LAST);
            r_wr_ready    <= (w_state_next == S_RUN);
            r_wr_err      <= w_wr_fire && !w_wr_ch_ok;
        end
    end

    // NOTE: the per-channel arrays are small register banks, not RAM, and
    // must hold CENTER from reset, so every entry is reset explicitly.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_cur[i]   <= CENTER_POS;
                r_tgt[i]   <= CENTER_POS;
                r_width[i] <= WIDTH_RST;
            end
            r_pwm       <= '0;
            r_at_target <= '1;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_wr_fire && w_wr_ch_ok && wr_ch == 4'(i)) begin
                    r_tgt[i] <= wr_pos;
                end
                if (w_upd_active && w_upd_idx == CNT_W'(i)) begin
                    r_cur[i]   <= w_cur_new;
                    r_width[i] <= w_width_new;
                end
                r_pwm[i]       <= (r_frame_cnt < r_width[i]) && ch_en[i];
                r_at_target[i] <= (r_tgt[i] == r_cur[i]);
            end
        end
    end

    assign wr_ready    = r_wr_ready;
    assign wr_err      = r_wr_err;
    assign pwm         = r_pwm;
    assign at_target   = r_at_target;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_servo_sched.sv
// -----------------------------------------------------------------------------
// tb_servo_sched: scoreboard bench for servo_sched.
//
// The clock is scaled so that a frame is short: 512 kHz / 400 Hz gives 1280
// ticks per frame. MIN_TICKS is 512, LSB_TICKS is 2, UPD_START is 1275, and
// the CENTER width is 768.
// At each frame start, the stimulus pushes the expected pulse widths and
// at_target values for that frame. The monitor measures the frame and
// compares it when the next frame_start arrives.
// -----------------------------------------------------------------------------
module tb_servo_sched;

    localparam int FT     = 1280;
    localparam int MIN_T  = 512;
    localparam int LSB_T  = 2;
    localparam int STEP_T = 4;
    localparam int NFR    = 37;

    logic       clk = 1'b0;
    logic       resetn;
    logic       wr_valid;
    logic       wr_ready;
    logic [3:0] wr_ch;
    logic [7:0] wr_pos;
    logic       wr_err;
    logic [3:0] ch_en;
    logic [3:0] pwm;
    logic [3:0] at_target;
    logic       frame_start;

    always #5 clk = ~clk;

    servo_sched #(
        .CLK_FREQUENCY(512000),
        .NUM_CH       (4),
        .FRAME_HZ     (400),
        .MIN_US       (1000),
        .MAX_US       (2000),
        .STEP         (STEP_T),
        .CENTER       (128)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_ch      (wr_ch),
        .wr_pos     (wr_pos),
        .wr_err     (wr_err),
        .ch_en      (ch_en),
        .pwm        (pwm),
        .at_target  (at_target),
        .frame_start(frame_start)
    );

    typedef struct {
        int         w [4];
        logic [3:0] at;
    } frame_exp_t;

    frame_exp_t exp_q [$];
    int         err_q [$];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         m_cur [4];
    int         m_tgt [4];
    int         fcnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: event did not occur as required", name);
    endtask

    // Reference frame counter. It follows the documented count sequence
    // and is used only to place stimulus in time.
    always @(posedge clk or negedge resetn) begin
        if (!resetn)        fcnt <= 0;
        else if (fcnt == FT - 1) fcnt <= 0;
        else                fcnt <= fcnt + 1;
    end

    function automatic int step_pos(input int cur, input int tgt);
        if (tgt - cur > STEP_T)      return cur + STEP_T;
        else if (cur - tgt > STEP_T) return cur - STEP_T;
        else                         return tgt;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_cur[i] = 128;
            m_tgt[i] = 128;
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < 4; i++) m_cur[i] = step_pos(m_cur[i], m_tgt[i]);
    endtask

    task automatic push_exp(input int ch3_override);
        frame_exp_t e;
        for (int i = 0; i < 4; i++) begin
            e.w[i]  = MIN_T + m_cur[i] * LSB_T;
            e.at[i] = (m_cur[i] == m_tgt[i]);
        end
        if (ch3_override >= 0) e.w[3] = ch3_override;
        exp_q.push_back(e);
    endtask

    task automatic wait_fs();
        int g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (!frame_start && g < FT + 10);
        if (!frame_start) fail_now("frame_start_timeout");
    endtask

    task automatic wait_cnt(input int n);
        int g = 0;
        while (fcnt != n && g < 2 * FT) begin
            @(negedge clk);
            g++;
        end
        if (fcnt != n) fail_now("wait_cnt_timeout");
    endtask

    task automatic do_write(input int ch, input int pos);
        wr_valid = 1'b1;
        wr_ch    = 4'(ch);
        wr_pos   = 8'(pos);
        check("wr_ready_run", {31'd0, wr_ready}, 1);
        @(negedge clk);
        wr_valid = 1'b0;
        if (ch < 4) m_tgt[ch] = pos;
    endtask

    // Monitor: measures each frame and checks it against the scoreboard.
    // It also checks that wr_err pulses last one cycle and were expected.
    initial begin : monitor
        int         nfs;
        int         cyc;
        int         cnt [4];
        logic [3:0] at_s;
        logic       prev_err;
        frame_exp_t e;
        nfs      = 0;
        cyc      = 0;
        at_s     = '0;
        prev_err = 1'b0;
        for (int i = 0; i < 4; i++) cnt[i] = 0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                nfs      = 0;
                cyc      = 0;
                prev_err = 1'b0;
            end else begin
                if (prev_err) check("wr_err_one_cycle", {31'd0, wr_err}, 0);
                else if (wr_err) begin
                    if (err_q.size() == 0) fail_now("wr_err_unexpected");
                    else void'(err_q.pop_front());
                end
                prev_err = wr_err && !prev_err;
                if (frame_start) begin
                    if (nfs >= 1) begin
                        if (exp_q.size() == 0) fail_now("scoreboard_underflow");
                        else begin
                            e = exp_q.pop_front();
                            check("frame_period", cyc, FT);
                            for (int i = 0; i < 4; i++)
                                check($sformatf("pwm_width_ch%0d", i), cnt[i], e.w[i]);
                            check("at_target_frame", {28'd0, at_s}, {28'd0, e.at});
                        end
                    end
                    nfs++;
                    cyc = 1;
                    for (int i = 0; i < 4; i++) cnt[i] = 0;
                end else begin
                    cyc++;
                end
                for (int i = 0; i < 4; i++) cnt[i] += int'(pwm[i]);
                if (cyc == 3) at_s = at_target;
            end
        end
    end

    initial begin : stimulus
        int  n;
        bit  post_valid;
        int  post_ch;
        int  post_pos;
        resetn     = 1'b0;
        wr_valid   = 1'b0;
        wr_ch      = '0;
        wr_pos     = '0;
        ch_en      = 4'hF;
        post_valid = 1'b0;
        post_ch    = 0;
        post_pos   = 0;
        model_reset();

        repeat (2) @(negedge clk);
        check("rst_pwm",         {28'd0, pwm}, 0);
        check("rst_wr_ready",    {31'd0, wr_ready}, 0);
        check("rst_wr_err",      {31'd0, wr_err}, 0);
        check("rst_frame_start", {31'd0, frame_start}, 0);
        check("rst_at_target",   {28'd0, at_target}, 32'hF);
        #2 resetn = 1'b1;
        @(negedge clk);
        check("ready_after_reset", {31'd0, wr_ready}, 1);

        for (int k = 1; k <= NFR; k++) begin
            wait_fs();
            wr_valid = 1'b0;
            model_step();
            if (post_valid) begin
                m_tgt[post_ch] = post_pos;
                post_valid     = 1'b0;
            end
            push_exp(-1);
            if (k == 3) begin
                wait_cnt(10);
                do_write(1, 200);
                check("at_target1_cyc1", {31'd0, at_target[1]}, 1);
                @(negedge clk);
                check("at_target1_cyc2", {31'd0, at_target[1]}, 0);
                wait_cnt(20);
                do_write(2, 130);
                wait_cnt(30);
                err_q.push_back(5);
                do_write(5, 10);
                wait_cnt(32);
                check("at_target_after_bad_ch", {28'd0, at_target}, 32'h9);
                wait_cnt(1275);
                check("ready_at_upd_start", {31'd0, wr_ready}, 1);
                wait_cnt(1276);
                check("ready_in_update", {31'd0, wr_ready}, 0);
                wait_cnt(1277);
                wr_valid = 1'b1;
                wr_ch    = 4'd0;
                wr_pos   = 8'd0;
                check("stall_1277", {31'd0, wr_ready}, 0);
                @(negedge clk);
                check("stall_1278", {31'd0, wr_ready}, 0);
                @(negedge clk);
                check("accept_1279", {31'd0, wr_ready}, 1);
                post_valid = 1'b1;
                post_ch    = 0;
                post_pos   = 0;
            end
        end

        // Asynchronous reset in the middle of a pulse.
        wait_fs();
        wait_cnt(300);
        check("pwm_before_reset", {28'd0, pwm}, 32'hF);
        #1 resetn = 1'b0;
        #1;
        check("pwm_async_reset", {28'd0, pwm}, 0);
        check("ready_async_reset", {31'd0, wr_ready}, 0);
        model_reset();
        repeat (2) @(negedge clk);
        #2 resetn = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_start && n < FT + 10);
        check("restart_to_frame_start", n, FT);
        model_step();
        push_exp(-1);

        // Drop ch_en[3] at count 300 and raise it again at count 400.
        // pwm[3] is then high for 300 + (768 - 400) = 668 cycles.
        wait_fs();
        model_step();
        push_exp(668);
        wait_cnt(300);
        check("pwm3_before_drop", {28'd0, pwm}, 32'hF);
        ch_en = 4'b0111;
        @(negedge clk);
        check("pwm3_dropped", {28'd0, pwm}, 32'h7);
        wait_cnt(400);
        ch_en = 4'hF;
        @(negedge clk);
        check("pwm3_raised", {28'd0, pwm}, 32'hF);

        wait_fs();
        repeat (2) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        check("wr_err_seen", err_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
